// File: rtl/seq_shift_add_mult.sv
// Iterative shift-add multiplier, one partial product per clock.
// Unsigned or two's-complement per operation, start/busy/done handshake.
module seq_shift_add_mult #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               tc,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN
  } state_t;

  state_t state;
  state_t state_nx;

  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [CW-1:0]    count;
  logic             sign;

  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH:0]   sum;
  logic             last;

  // Magnitude of the most negative value wraps to 2^(W-1), exact as unsigned.
  always_comb begin
    mag_a = a;
    mag_b = b;
    if (tc && a[WIDTH-1]) mag_a = ~a + WIDTH'(1);
    if (tc && b[WIDTH-1]) mag_b = ~b + WIDTH'(1);
  end

  always_comb begin
    sum = {1'b0, hi};
    if (lo[0]) sum = {1'b0, hi} + {1'b0, mcand};
  end

  assign last = (count == CW'(WIDTH - 1));
  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (start) state_nx = RUN;
      RUN:  if (last)  state_nx = FIN;
      FIN:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand   <= '0;
      hi      <= '0;
      lo      <= '0;
      count   <= '0;
      sign    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            mcand <= mag_a;
            lo    <= mag_b;
            hi    <= '0;
            count <= '0;
            sign  <= tc & (a[WIDTH-1] ^ b[WIDTH-1]);
          end
        end
        RUN: begin
          hi    <= sum[WIDTH:1];
          lo    <= {sum[0], lo[WIDTH-1:1]};
          count <= count + CW'(1);
        end
        FIN: begin
          product <= sign ? -{hi, lo} : {hi, lo};
          done    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_shift_add_mult.sv
// Bench for seq_shift_add_mult: WIDTH=2 and WIDTH=8 instances
// against an arithmetic reference plus literal directed results.
module tb_seq_shift_add_mult;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic        s8 = 1'b0, tc8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        busy8, done8;
  logic [15:0] p8;

  logic        s2 = 1'b0, tc2 = 1'b0;
  logic [1:0]  a2 = '0, b2 = '0;
  logic        busy2, done2;
  logic [3:0]  p2;

  seq_shift_add_mult #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(s8), .tc(tc8),
    .a(a8), .b(b8), .busy(busy8), .done(done8), .product(p8)
  );

  seq_shift_add_mult #(.WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(s2), .tc(tc2),
    .a(a2), .b(b2), .busy(busy2), .done(done2), .product(p2)
  );

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_tot++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else
      n_pass++;
  endtask

  function automatic logic [63:0] mul_ref(input int w,
      input logic [31:0] x, input logic [31:0] y, input logic t);
    longint sx, sy, p;
    sx = longint'(x);
    sy = longint'(y);
    if (t && x[w-1]) sx = sx - (longint'(1) << w);
    if (t && y[w-1]) sy = sy - (longint'(1) << w);
    p = sx * sy;
    return 64'(p) & ((64'd1 << (2 * w)) - 64'd1);
  endfunction

  // Reference: result due WIDTH+1 edges after an accepted start.
  int          m8_cnt = 0;
  logic        m8_done = 1'b0;
  logic [15:0] m8_prod = '0, m8_pend = '0;
  int          m2_cnt = 0;
  logic        m2_done = 1'b0;
  logic [3:0]  m2_prod = '0, m2_pend = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m8_cnt <= 0; m8_done <= 1'b0; m8_prod <= '0;
    end else begin
      m8_done <= 1'b0;
      if (m8_cnt != 0) begin
        m8_cnt <= m8_cnt - 1;
        if (m8_cnt == 1) begin
          m8_done <= 1'b1;
          m8_prod <= m8_pend;
        end
      end else if (s8) begin
        m8_cnt  <= 9;
        m8_pend <= 16'(mul_ref(8, 32'(a8), 32'(b8), tc8));
      end
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m2_cnt <= 0; m2_done <= 1'b0; m2_prod <= '0;
    end else begin
      m2_done <= 1'b0;
      if (m2_cnt != 0) begin
        m2_cnt <= m2_cnt - 1;
        if (m2_cnt == 1) begin
          m2_done <= 1'b1;
          m2_prod <= m2_pend;
        end
      end else if (s2) begin
        m2_cnt  <= 3;
        m2_pend <= 4'(mul_ref(2, 32'(a2), 32'(b2), tc2));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("busy8", 64'(busy8), 64'(m8_cnt != 0));
      chk("done8", 64'(done8), 64'(m8_done));
      chk("product8", 64'(p8), 64'(m8_prod));
      chk("busy2", 64'(busy2), 64'(m2_cnt != 0));
      chk("done2", 64'(done2), 64'(m2_done));
      chk("product2", 64'(p2), 64'(m2_prod));
    end
  end

  task automatic op8(input logic [7:0] a, input logic [7:0] b,
                     input logic t, output logic [15:0] p,
                     output int lat);
    @(posedge clk); #2;
    s8 = 1'b1; a8 = a; b8 = b; tc8 = t;
    @(posedge clk); #2;
    s8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); tc8 = 1'($urandom);
    lat = 0;
    while (!done8 && lat < 30) begin
      @(posedge clk); #2;
      lat++;
    end
    p = p8;
  endtask

  task automatic op2(input logic [1:0] a, input logic [1:0] b,
                     input logic t, output logic [3:0] p,
                     output int lat);
    @(posedge clk); #2;
    s2 = 1'b1; a2 = a; b2 = b; tc2 = t;
    @(posedge clk); #2;
    s2 = 1'b0;
    a2 = 2'($urandom); b2 = 2'($urandom); tc2 = 1'($urandom);
    lat = 0;
    while (!done2 && lat < 30) begin
      @(posedge clk); #2;
      lat++;
    end
    p = p2;
  endtask

  initial begin
    logic [15:0] p;
    logic [3:0]  q;
    int          lat, lows, extra;

    #1 rst_n = 1'b0;
    #2;
    chk("rst_busy8", 64'(busy8), 64'd0);
    chk("rst_done8", 64'(done8), 64'd0);
    chk("rst_prod8", 64'(p8), 64'd0);
    chk("rst_prod2", 64'(p2), 64'd0);
    @(posedge clk); #2 rst_n = 1'b1;

    for (int t = 0; t < 2; t++)
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++) begin
          op2(2'(i), 2'(j), 1'(t), q, lat);
          chk("lat2", 64'(lat), 64'd3);
        end
    op2(2'd3, 2'd3, 1'b0, q, lat);
    chk("w2_3x3", 64'(q), 64'h9);
    op2(2'd2, 2'd2, 1'b1, q, lat);
    chk("w2_m2xm2", 64'(q), 64'h4);
    op2(2'd2, 2'd1, 1'b1, q, lat);
    chk("w2_m2x1", 64'(q), 64'hE);

    op8(8'hFF, 8'hFF, 1'b0, p, lat);
    chk("lat_ffxff", 64'(lat), 64'd9);
    chk("u_ffxff", 64'(p), 64'hFE01);
    op8(8'h00, 8'hAB, 1'b0, p, lat);
    chk("u_0xab", 64'(p), 64'h0000);
    op8(8'h80, 8'h80, 1'b1, p, lat);
    chk("s_80x80", 64'(p), 64'h4000);
    op8(8'hFF, 8'h01, 1'b1, p, lat);
    chk("s_ffx01", 64'(p), 64'hFFFF);
    op8(8'h7F, 8'h80, 1'b1, p, lat);
    chk("s_7fx80", 64'(p), 64'hC080);

    // Start pulsed mid-operation must be dropped.
    @(posedge clk); #2;
    s8 = 1'b1; a8 = 8'd3; b8 = 8'd5; tc8 = 1'b0;
    @(posedge clk); #2 s8 = 1'b0;
    lows = 0;
    repeat (3) begin
      @(posedge clk); #2;
      if (!busy8) lows++;
    end
    s8 = 1'b1; a8 = 8'd7; b8 = 8'd7;
    @(posedge clk); #2 s8 = 1'b0;
    lat = 0;
    while (!done8 && lat < 30) begin
      if (!busy8) lows++;
      @(posedge clk); #2;
      lat++;
    end
    chk("ign_prod", 64'(p8), 64'd15);
    chk("ign_busy_lows", 64'(lows), 64'd0);
    extra = 0;
    repeat (12) begin
      @(posedge clk); #2;
      if (done8) extra++;
    end
    chk("ign_extra_done", 64'(extra), 64'd0);

    // Back-to-back: new start presented in the done cycle.
    @(posedge clk); #2;
    s8 = 1'b1; a8 = 8'd3; b8 = 8'd5; tc8 = 1'b0;
    @(posedge clk); #2 s8 = 1'b0;
    lat = 0;
    while (!done8 && lat < 30) begin
      @(posedge clk); #2;
      lat++;
    end
    chk("b2b_first", 64'(p8), 64'd15);
    s8 = 1'b1; a8 = 8'd12; b8 = 8'd10;
    @(posedge clk); #2 s8 = 1'b0;
    chk("b2b_no_gap", 64'(busy8), 64'd1);
    lat = 0;
    while (!done8 && lat < 30) begin
      @(posedge clk); #2;
      lat++;
    end
    chk("b2b_lat", 64'(lat), 64'd9);
    chk("b2b_prod", 64'(p8), 64'd120);

    // Asynchronous reset mid-RUN.
    @(posedge clk); #2;
    s8 = 1'b1; a8 = 8'h55; b8 = 8'h33;
    @(posedge clk); #2 s8 = 1'b0;
    repeat (3) begin
      @(posedge clk); #2;
    end
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 64'(busy8), 64'd0);
    chk("arst_done", 64'(done8), 64'd0);
    chk("arst_prod", 64'(p8), 64'd0);
    #4 rst_n = 1'b1;
    extra = 0;
    repeat (15) begin
      @(posedge clk); #2;
      if (done8) extra++;
    end
    chk("arst_no_done", 64'(extra), 64'd0);
    op8(8'd12, 8'd10, 1'b0, p, lat);
    chk("arst_after_lat", 64'(lat), 64'd9);
    chk("arst_after_prod", 64'(p), 64'd120);

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
